acl_spi_responder: RTL and testbench
====================================

ACL_SPI_RESPONDER -- requirements
Module: acl_spi_responder

Interface
REQ-001 SHALL have parameter SPI_DEV_ID, default 8'hAD, value returned at register 0x00.
REQ-002 SHALL have parameter SPI_PART_ID, default 8'hF2, value returned at register 0x02.
REQ-003 clk  input  1  system clock (100 MHz); all logic on rising edge; single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 spi_sclk  input  1  SPI clock from master; asynchronous; at most clk/8.
REQ-006 spi_csn  input  1  chip select, active low; asynchronous.
REQ-007 spi_mosi  input  1  master-out data; asynchronous.
REQ-008 spi_miso  output  1  slave-out data; 0 while spi_csn high.
REQ-009 acc_x, acc_y, acc_z  input  12 each  signed acceleration samples.
REQ-010 wr_valid  output  1  one-cycle pulse per completed write data byte.
REQ-011 wr_addr  output  8  address of the byte written; valid with wr_valid.
REQ-012 wr_data  output  8  data of the byte written; valid with wr_valid.
REQ-013 busy  output  1  high while a transaction is in progress (state != IDLE).

Function
REQ-014 SHALL pass spi_sclk, spi_csn, spi_mosi through 2-flop synchronizers; edges detected on synchronized values.
REQ-015 SPI mode 0: MOSI sampled on synchronized SCLK rising edge, MSB first; MISO updated on synchronized SCLK falling edge.
REQ-016 FSM states: IDLE, CMD, ADDR, DATA_RD, DATA_WR, IGNORE.
REQ-017 IDLE -> CMD on synchronized CSN falling edge; 3-bit bit counter cleared.
REQ-018 CMD after 8 bits: 0x0B -> ADDR (read), 0x0A -> ADDR (write), other -> IGNORE.
REQ-019 ADDR after 8 bits: latch address; -> DATA_RD or DATA_WR.
REQ-020 DATA_RD: load shift register with reg[addr] before the falling edge following the 16th rising edge; that falling edge presents bit 7; after each 8th bit address increments and next byte loads.
REQ-021 DATA_WR: after each 8th bit, pulse wr_valid one cycle with wr_addr/wr_data; update register if writable; address increments.
REQ-022 Address increment 8-bit, wraps 0xFF -> 0x00.
REQ-023 Register map: 0x00 SPI_DEV_ID; 0x01 0x1D; 0x02 SPI_PART_ID; 0x08/0x09/0x0A = acc_x/y/z[11:4]; 0x0E/0x10/0x12 = acc_x/y/z[7:0]; 0x0F/0x11/0x13 = {4 sign bits, acc_x/y/z[11:8]}; 0x2C FILTER_CTL (R/W, reset 0x13); 0x2D POWER_CTL (R/W, reset 0x00); all others read 0x00.
REQ-024 Write to 0x1F with 0x52 SHALL restore FILTER_CTL/POWER_CTL reset values; writes to read-only addresses ignored but still pulse wr_valid.
REQ-025 acc_x/y/z SHALL be snapshotted into shadow registers on CSN falling edge; reads use only the shadow (coherent multi-byte read).
REQ-026 Synchronized CSN rising edge in any state -> IDLE next cycle; partial byte discarded, no wr_valid; spi_miso forced 0.
REQ-027 IGNORE: MISO held 0, MOSI ignored until CSN rises.
REQ-028 CSN falling edge while not IDLE is impossible by construction (rise precedes fall); simultaneous SCLK edge and CSN rise: CSN rise wins.

Reset
REQ-029 On rst: state IDLE, counters 0, spi_miso 0, wr_valid 0, wr_addr 0, wr_data 0, busy 0, FILTER_CTL 0x13, POWER_CTL 0x00, shadows 0, synchronizer flops to idle levels (sclk 0, csn 1, mosi 0).
REQ-030 rst asserted mid-transaction SHALL abort it; block then waits for a fresh CSN falling edge.

Structure
REQ-031 Shared package acl_spi_pkg SHALL hold the FSM state enum, command codes (0x0A, 0x0B), register address constants, reset values, and soft-reset key 0x52.
REQ-032 One sub-module: acl_spi_sync (2-flop synchronizer plus edge detect), instantiated per SPI input.

Verification
REQ-033 Read 0x0B,0x00 then 3 bytes -> MISO returns 0xAD, 0x1D, 0xF2.
REQ-034 acc_x=12'hF83, CSN fall, then acc_x changes to 0; read 0x0B,0x0E, 2 bytes -> 0x83, 0xFF.
REQ-035 Write 0x0A,0x2D,0x02 -> wr_valid once with addr 0x2D, data 0x02; subsequent read of 0x2D returns 0x02.
REQ-036 Write 0x52 to 0x1F after REQ-035 -> read 0x2D returns 0x00, 0x2C returns 0x13.
REQ-037 Command 0x0A, address 0x2D, 5 data bits, CSN high -> no wr_valid, busy low within 4 clk, POWER_CTL unchanged.
REQ-038 Read starting 0xFF, 2 bytes -> 0x00 then 0xAD (wrap); invalid command 0x55 -> MISO 0 for whole transaction.

Source files
------------

// File: rtl/acl_spi_pkg.sv
// Shared definitions for the accelerometer-style SPI responder: FSM states,
// command codes, register map addresses and reset values.
package acl_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA_RD,
        ST_DATA_WR,
        ST_IGNORE
    } spi_state_t;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    localparam logic [7:0] ADDR_DEV_ID     = 8'h00;
    localparam logic [7:0] ADDR_MEMS_ID    = 8'h01;
    localparam logic [7:0] ADDR_PART_ID    = 8'h02;
    localparam logic [7:0] ADDR_XDATA      = 8'h08;
    localparam logic [7:0] ADDR_YDATA      = 8'h09;
    localparam logic [7:0] ADDR_ZDATA      = 8'h0A;
    localparam logic [7:0] ADDR_XDATA_L    = 8'h0E;
    localparam logic [7:0] ADDR_XDATA_H    = 8'h0F;
    localparam logic [7:0] ADDR_YDATA_L    = 8'h10;
    localparam logic [7:0] ADDR_YDATA_H    = 8'h11;
    localparam logic [7:0] ADDR_ZDATA_L    = 8'h12;
    localparam logic [7:0] ADDR_ZDATA_H    = 8'h13;
    localparam logic [7:0] ADDR_SOFT_RESET = 8'h1F;
    localparam logic [7:0] ADDR_FILTER_CTL = 8'h2C;
    localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;

    localparam logic [7:0] MEMS_ID_VAL    = 8'h1D;
    localparam logic [7:0] FILTER_CTL_RST = 8'h13;
    localparam logic [7:0] POWER_CTL_RST  = 8'h00;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

endpackage

// File: rtl/acl_spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus rise/fall pulses
// derived from the synchronized level.
module acl_spi_sync #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= IDLE_LEVEL;
            sync_q <= IDLE_LEVEL;
            prev_q <= IDLE_LEVEL;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/acl_spi_responder.sv
// SPI mode-0 slave exposing a small accelerometer-style register map with
// coherent sample snapshots, auto-incrementing burst reads and writes.
module acl_spi_responder #(
    parameter logic [7:0] SPI_DEV_ID  = 8'hAD,
    parameter logic [7:0] SPI_PART_ID = 8'hF2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [11:0] acc_x,
    input  logic [11:0] acc_y,
    input  logic [11:0] acc_z,
    output logic        wr_valid,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);
    import acl_spi_pkg::*;

    logic sclk_level, sclk_rise, sclk_fall;
    logic csn_level, csn_rise, csn_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    acl_spi_sync #(.IDLE_LEVEL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .async_in(spi_sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    acl_spi_sync #(.IDLE_LEVEL(1'b1)) u_sync_csn (
        .clk(clk), .rst(rst), .async_in(spi_csn),
        .level(csn_level), .rise(csn_rise), .fall(csn_fall)
    );

    acl_spi_sync #(.IDLE_LEVEL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .async_in(spi_mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync_bits;
    assign unused_sync_bits = ^{sclk_level, csn_level, mosi_rise, mosi_fall};

    spi_state_t state, state_next;

    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  shift_out;
    logic [7:0]  addr;
    logic        is_write;
    logic        miso_q;
    logic [7:0]  filter_ctl;
    logic [7:0]  power_ctl;
    logic [11:0] shadow_x, shadow_y, shadow_z;

    logic [7:0] byte_in;
    logic       byte_done;
    logic [7:0] addr_inc;

    assign byte_in   = {shift_in, mosi_level};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign addr_inc  = addr + 8'd1;

    // Reads see only the shadow copies so a multi-byte sample stays coherent.
    function automatic logic [7:0] reg_read(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        case (a)
            ADDR_DEV_ID:     r = SPI_DEV_ID;
            ADDR_MEMS_ID:    r = MEMS_ID_VAL;
            ADDR_PART_ID:    r = SPI_PART_ID;
            ADDR_XDATA:      r = shadow_x[11:4];
            ADDR_YDATA:      r = shadow_y[11:4];
            ADDR_ZDATA:      r = shadow_z[11:4];
            ADDR_XDATA_L:    r = shadow_x[7:0];
            ADDR_XDATA_H:    r = {{4{shadow_x[11]}}, shadow_x[11:8]};
            ADDR_YDATA_L:    r = shadow_y[7:0];
            ADDR_YDATA_H:    r = {{4{shadow_y[11]}}, shadow_y[11:8]};
            ADDR_ZDATA_L:    r = shadow_z[7:0];
            ADDR_ZDATA_H:    r = {{4{shadow_z[11]}}, shadow_z[11:8]};
            ADDR_FILTER_CTL: r = filter_ctl;
            ADDR_POWER_CTL:  r = power_ctl;
            default:         r = 8'h00;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A chip-select release always wins, even against a same-cycle SCLK edge.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (csn_fall) begin
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (byte_done) begin
                    if (byte_in == CMD_READ || byte_in == CMD_WRITE) begin
                        state_next = ST_ADDR;
                    end else begin
                        state_next = ST_IGNORE;
                    end
                end
            end
            ST_ADDR: begin
                if (byte_done) begin
                    state_next = is_write ? ST_DATA_WR : ST_DATA_RD;
                end
            end
            default: state_next = state;
        endcase
        if (state != ST_IDLE && csn_rise) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= 3'd0;
            shift_in   <= 7'd0;
            shift_out  <= 8'h00;
            addr       <= 8'h00;
            is_write   <= 1'b0;
            miso_q     <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= 8'h00;
            wr_data    <= 8'h00;
            filter_ctl <= FILTER_CTL_RST;
            power_ctl  <= POWER_CTL_RST;
            shadow_x   <= 12'd0;
            shadow_y   <= 12'd0;
            shadow_z   <= 12'd0;
        end else begin
            wr_valid <= 1'b0;
            if (state == ST_IDLE) begin
                miso_q <= 1'b0;
                if (csn_fall) begin
                    bit_cnt  <= 3'd0;
                    shadow_x <= acc_x;
                    shadow_y <= acc_y;
                    shadow_z <= acc_z;
                end
            end else if (csn_rise) begin
                miso_q  <= 1'b0;
                bit_cnt <= 3'd0;
            end else begin
                if (sclk_rise) begin
                    shift_in <= byte_in[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (byte_done) begin
                        case (state)
                            ST_CMD: is_write <= (byte_in == CMD_WRITE);
                            ST_ADDR: begin
                                addr      <= byte_in;
                                shift_out <= reg_read(byte_in);
                            end
                            ST_DATA_RD: begin
                                addr      <= addr_inc;
                                shift_out <= reg_read(addr_inc);
                            end
                            ST_DATA_WR: begin
                                wr_valid <= 1'b1;
                                wr_addr  <= addr;
                                wr_data  <= byte_in;
                                addr     <= addr_inc;
                                if (addr == ADDR_FILTER_CTL) begin
                                    filter_ctl <= byte_in;
                                end else if (addr == ADDR_POWER_CTL) begin
                                    power_ctl <= byte_in;
                                end else if (addr == ADDR_SOFT_RESET && byte_in == SOFT_RESET_KEY) begin
                                    filter_ctl <= FILTER_CTL_RST;
                                    power_ctl  <= POWER_CTL_RST;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                if (sclk_fall && state == ST_DATA_RD) begin
                    miso_q    <= shift_out[7];
                    shift_out <= {shift_out[6:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso = miso_q;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_acl_spi_responder.sv
// Self-checking bench for acl_spi_responder: directed register-map scenarios
// followed by randomized bursts checked against a behavioural register model.
module tb_acl_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sclk;
    logic        spi_csn;
    logic        spi_mosi;
    logic        spi_miso;
    logic [11:0] acc_x, acc_y, acc_z;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    acl_spi_responder dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] m_sh [3];
    logic [7:0]  m_filter;
    logic [7:0]  m_power;
    logic [15:0] wr_log [$];
    logic [7:0]  rd_buf [8];
    logic [7:0]  wbuf [4];

    always @(negedge clk) begin
        if (wr_valid) wr_log.push_back({wr_addr, wr_data});
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    // Reference register map: sample bytes come from sign-extended integer arithmetic.
    function automatic logic [7:0] model_read(input logic [7:0] a);
        int v;
        int axis;
        if (a == 8'h00) return 8'hAD;
        if (a == 8'h01) return 8'h1D;
        if (a == 8'h02) return 8'hF2;
        if (a == 8'h2C) return m_filter;
        if (a == 8'h2D) return m_power;
        if (a >= 8'h08 && a <= 8'h0A) begin
            axis = int'(a) - 8;
            v = int'($signed(m_sh[axis]));
            return 8'((v >>> 4) & 255);
        end
        if (a >= 8'h0E && a <= 8'h13) begin
            axis = (int'(a) - 14) / 2;
            v = int'($signed(m_sh[axis]));
            if (a[0] == 1'b0) return 8'(v & 255);
            return 8'((v >>> 8) & 255);
        end
        return 8'h00;
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
        if (a == 8'h2C) m_filter = d;
        else if (a == 8'h2D) m_power = d;
        else if (a == 8'h1F && d == 8'h52) begin
            m_filter = 8'h13;
            m_power  = 8'h00;
        end
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #80;
            spi_sclk = 1'b1;
            rx[i] = spi_miso;
            #80;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic csn_start();
        @(negedge clk);
        spi_csn = 1'b0;
        m_sh[0] = acc_x;
        m_sh[1] = acc_y;
        m_sh[2] = acc_z;
        #100;
    endtask

    task automatic csn_stop();
        #100;
        @(negedge clk);
        spi_csn = 1'b1;
        #100;
    endtask

    task automatic read_burst(input logic [7:0] a, input int n, input bit change, input logic [35:0] next_acc);
        logic [7:0] rx;
        csn_start();
        if (change) {acc_x, acc_y, acc_z} = next_acc;
        spi_byte(8'h0B, rx);
        check_output("rd_cmd_miso", rx, 8'h00);
        spi_byte(a, rx);
        check_output("rd_addr_miso", rx, 8'h00);
        for (int k = 0; k < n; k++) begin
            spi_byte(8'($urandom), rx);
            rd_buf[k] = rx;
            check_output("rd_data", {a + 8'(k), rx}, {a + 8'(k), model_read(a + 8'(k))});
        end
        csn_stop();
    endtask

    task automatic write_burst(input logic [7:0] a, input int n);
        logic [7:0] rx;
        wr_log.delete();
        csn_start();
        spi_byte(8'h0A, rx);
        spi_byte(a, rx);
        for (int k = 0; k < n; k++) begin
            spi_byte(wbuf[k], rx);
            model_write(a + 8'(k), wbuf[k]);
        end
        csn_stop();
        check_output("wr_count", wr_log.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < wr_log.size()) check_output("wr_event", wr_log[k], {a + 8'(k), wbuf[k]});
        end
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] ra;
        int n;
        int pick;

        rst = 1'b1;
        spi_sclk = 1'b0;
        spi_csn = 1'b1;
        spi_mosi = 1'b0;
        acc_x = 12'd0;
        acc_y = 12'd0;
        acc_z = 12'd0;
        m_sh[0] = 12'd0;
        m_sh[1] = 12'd0;
        m_sh[2] = 12'd0;
        m_filter = 8'h13;
        m_power = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_miso", spi_miso, 1'b0);
        check_output("rst_wr_valid", wr_valid, 1'b0);
        check_output("rst_wr_addr", wr_addr, 8'h00);
        check_output("rst_wr_data", wr_data, 8'h00);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        $display("[TB] identification read");
        read_burst(8'h00, 3, 1'b0, 36'd0);
        check_output("id_dev", rd_buf[0], 8'hAD);
        check_output("id_mems", rd_buf[1], 8'h1D);
        check_output("id_part", rd_buf[2], 8'hF2);

        $display("[TB] coherent sample snapshot");
        acc_x = 12'hF83;
        read_burst(8'h0E, 2, 1'b1, {12'h000, acc_y, acc_z});
        check_output("snap_lo", rd_buf[0], 8'h83);
        check_output("snap_hi", rd_buf[1], 8'hFF);

        $display("[TB] power control write and soft reset");
        wbuf[0] = 8'h02;
        write_burst(8'h2D, 1);
        read_burst(8'h2D, 1, 1'b0, 36'd0);
        check_output("power_wr", rd_buf[0], 8'h02);
        wbuf[0] = 8'h52;
        write_burst(8'h1F, 1);
        read_burst(8'h2D, 1, 1'b0, 36'd0);
        check_output("soft_rst_power", rd_buf[0], 8'h00);
        read_burst(8'h2C, 1, 1'b0, 36'd0);
        check_output("soft_rst_filter", rd_buf[0], 8'h13);

        $display("[TB] aborted write");
        wbuf[0] = 8'h5A;
        write_burst(8'h2D, 1);
        wr_log.delete();
        csn_start();
        spi_byte(8'h0A, rx);
        spi_byte(8'h2D, rx);
        for (int i = 0; i < 5; i++) begin
            spi_mosi = 1'b1;
            #80;
            spi_sclk = 1'b1;
            #80;
            spi_sclk = 1'b0;
        end
        #100;
        @(negedge clk);
        spi_csn = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_output("abort_busy", busy, 1'b0);
        check_output("abort_miso", spi_miso, 1'b0);
        #100;
        check_output("abort_no_wr", wr_log.size(), 0);
        read_burst(8'h2D, 1, 1'b0, 36'd0);
        check_output("abort_power", rd_buf[0], 8'h5A);

        $display("[TB] address wrap and invalid command");
        read_burst(8'hFF, 2, 1'b0, 36'd0);
        check_output("wrap_ff", rd_buf[0], 8'h00);
        check_output("wrap_00", rd_buf[1], 8'hAD);
        wr_log.delete();
        csn_start();
        spi_byte(8'h55, rx);
        check_output("bad_cmd_miso", rx, 8'h00);
        for (int k = 0; k < 3; k++) begin
            spi_byte(8'($urandom), rx);
            check_output("ignore_miso", rx, 8'h00);
            check_output("ignore_busy", busy, 1'b1);
        end
        csn_stop();
        check_output("ignore_no_wr", wr_log.size(), 0);

        $display("[TB] randomized bursts");
        for (int it = 0; it < 20; it++) begin
            acc_x = 12'($urandom);
            acc_y = 12'($urandom);
            acc_z = 12'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                pick = $urandom_range(0, 3);
                case (pick)
                    0: ra = 8'($urandom_range(0, 8'h14));
                    1: ra = 8'h2C;
                    2: ra = 8'hFE;
                    default: ra = 8'($urandom);
                endcase
                n = $urandom_range(1, 4);
                read_burst(ra, n, 1'b1, 36'({$urandom, $urandom}));
            end else begin
                pick = $urandom_range(0, 3);
                case (pick)
                    0: ra = 8'h2C;
                    1: ra = 8'h2D;
                    2: ra = 8'h1F;
                    default: ra = 8'($urandom);
                endcase
                n = $urandom_range(1, 3);
                for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
                if (ra == 8'h1F && $urandom_range(0, 1) == 1) wbuf[0] = 8'h52;
                write_burst(ra, n);
                read_burst(8'h2C, 2, 1'b0, 36'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
